// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in frame receiver.
// Parity bit is present only when SIPO_FRAME_PARITY_EN is defined.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

`ifdef SIPO_FRAME_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_width(input int cmd_w, input int data_w, input int parity);
    return cmd_w + data_w + parity;
  endfunction

  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Bit-serial shifter: counts FRAME_W bits, strobes done with the assembled word,
// and flags an abort when the enable drops mid-frame.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int FRAME_W   = 32,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = cnt_width(FRAME_W)
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               din,
  input  logic               en_sipo,
  output logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               abort
);

  sipo_state_e        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [FRAME_W-1:0] sreg, sreg_nxt, shifted;
  logic               abort_nxt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
      abort <= abort_nxt;
    end
  end

  // Completed word is taken from the shift input so the top can register it
  // on the same edge that samples the last bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    abort_nxt = 1'b0;
    done      = 1'b0;
    shifted   = (LSB_FIRST != 0) ? {din, sreg[FRAME_W-1:1]} : {sreg[FRAME_W-2:0], din};
    frame     = shifted;
    unique case (state)
      IDLE: begin
        if (en_sipo) begin
          state_nxt = SHIFT;
          cnt_nxt   = CNT_W'(1);
          sreg_nxt  = shifted;
        end
      end
      SHIFT: begin
        if (!en_sipo) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sreg_nxt  = '0;
          abort_nxt = 1'b1;
        end else if (cnt == CNT_W'(FRAME_W - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sreg_nxt  = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          sreg_nxt = shifted;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: shift core plus a one-deep held-frame register with
// valid/ready handshake, overrun and abort pulses. Optional parity: SIPO_FRAME_PARITY_EN.
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int CMD_W     = 8,
  parameter int DATA_W    = 24,
  parameter int LSB_FIRST = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              din,
  input  logic              en_sipo,
  input  logic              frame_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] data,
  output logic              frame_valid,
  output logic              overrun,
  output logic              abort,
  output logic              parity_err
);

  localparam int FRAME_W  = frame_width(CMD_W, DATA_W, PARITY_BITS);
  // Parity trails the body, so it lands at the top when LSB-first, bottom otherwise.
  localparam int BODY_LSB = (LSB_FIRST != 0) ? 0 : PARITY_BITS;

  logic [FRAME_W-1:0] frame;
  logic               done;
  logic [CMD_W-1:0]   cmd_in;
  logic [DATA_W-1:0]  data_in;
  logic               load;

  sipo_shift_core #(
    .FRAME_W   (FRAME_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (din),
    .en_sipo (en_sipo),
    .frame   (frame),
    .done    (done),
    .abort   (abort)
  );

  assign data_in = frame[BODY_LSB +: DATA_W];
  assign cmd_in  = frame[BODY_LSB + DATA_W +: CMD_W];
  assign load    = done && (!frame_valid || frame_ready);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cmd         <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= done && !load;
      if (load) begin
        cmd         <= cmd_in;
        data        <= data_in;
        frame_valid <= 1'b1;
      end else if (!done && frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  localparam int PAR_IDX = (LSB_FIRST != 0) ? FRAME_W - 1 : 0;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       parity_err <= 1'b0;
    else if (load) parity_err <= frame[PAR_IDX] ^ (^{cmd_in, data_in});
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: scoreboard queue of expected frame/overrun/abort
// events, popped by a negedge monitor; two DUTs cover LSB-first and MSB-first builds.
module tb_sipo_frame_rx;

`ifdef SIPO_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int K_FRM = 0;
  localparam int K_OVR = 1;
  localparam int K_ABT = 2;

  typedef struct {
    int          inst;
    int          kind;
    logic [15:0] c;
    logic [63:0] d;
    logic        pe;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_din = 1'b0, a_en = 1'b0, a_rdy = 1'b0;
  logic [7:0]  a_cmd;
  logic [23:0] a_data;
  logic        a_vld, a_ovr, a_abt, a_pe;

  logic        b_din = 1'b0, b_en = 1'b0, b_rdy = 1'b1;
  logic [3:0]  b_cmd;
  logic [7:0]  b_data;
  logic        b_vld, b_ovr, b_abt, b_pe;

  sipo_frame_rx u_dut_a (
    .sys_clk(clk), .rst(rst), .din(a_din), .en_sipo(a_en), .frame_ready(a_rdy),
    .cmd(a_cmd), .data(a_data), .frame_valid(a_vld), .overrun(a_ovr),
    .abort(a_abt), .parity_err(a_pe)
  );

  sipo_frame_rx #(.CMD_W(4), .DATA_W(8), .LSB_FIRST(0)) u_dut_b (
    .sys_clk(clk), .rst(rst), .din(b_din), .en_sipo(b_en), .frame_ready(b_rdy),
    .cmd(b_cmd), .data(b_data), .frame_valid(b_vld), .overrun(b_ovr),
    .abort(b_abt), .parity_err(b_pe)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input int kind, input logic [15:0] c,
                      input logic [63:0] d, input logic pe);
    ev_t e;
    e.inst = inst; e.kind = kind; e.c = c; e.d = d; e.pe = pe;
    q.push_back(e);
  endtask

  // Expected frame; parity_err is 1 when the sent parity bit breaks even parity.
  task automatic exp_frame(input int inst, input logic [63:0] v, input int w, input int cw,
                           input bit pb);
    logic [63:0] body;
    logic        pe;
    body = v & ((64'd1 << w) - 64'd1);
    pe   = (PAR != 0) ? (pb ^ (^body)) : 1'b0;
    push(inst, K_FRM, 16'(body >> (w - cw)), body & ((64'd1 << (w - cw)) - 64'd1), pe);
  endtask

  task automatic handle(input int inst, input int kind, input logic [15:0] c,
                        input logic [63:0] d, input logic pe);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got inst=%0d kind=%0d cmd=%0h data=%0h perr=%0b expected none",
               inst, kind, c, d, pe);
    end else begin
      e = q.pop_front();
      if (e.inst != inst || e.kind != kind ||
          (kind == K_FRM && (e.c !== c || e.d !== d || e.pe !== pe))) begin
        failures++;
        $display("FAIL event: got inst=%0d kind=%0d cmd=%0h data=%0h perr=%0b expected inst=%0d kind=%0d cmd=%0h data=%0h perr=%0b",
                 inst, kind, c, d, pe, e.inst, e.kind, e.c, e.d, e.pe);
      end
    end
  endtask

  // Monitor: a frame event is a valid rise or a new word loaded under valid.
  logic        pva = 1'b0, pvb = 1'b0;
  logic [31:0] pa  = '0;
  logic [11:0] pb  = '0;
  always @(negedge clk) begin
    if (rst) begin
      pva = 1'b0;
      pvb = 1'b0;
    end else begin
      if (a_vld && (!pva || {a_cmd, a_data} != pa))
        handle(0, K_FRM, 16'(a_cmd), 64'(a_data), a_pe);
      if (a_ovr) handle(0, K_OVR, 16'd0, 64'd0, 1'b0);
      if (a_abt) handle(0, K_ABT, 16'd0, 64'd0, 1'b0);
      if (b_vld && (!pvb || {b_cmd, b_data} != pb))
        handle(1, K_FRM, 16'(b_cmd), 64'(b_data), b_pe);
      if (b_ovr) handle(1, K_OVR, 16'd0, 64'd0, 1'b0);
      if (b_abt) handle(1, K_ABT, 16'd0, 64'd0, 1'b0);
      pva = a_vld; pa = {a_cmd, a_data};
      pvb = b_vld; pb = {b_cmd, b_data};
    end
  end

  // inst 0 sends LSB first, inst 1 MSB first; parity bit trails when enabled.
  task automatic send_frame(input int inst, input logic [63:0] v, input int w,
                            input bit pb_, input bit rdy_last);
    int n;
    bit b;
    n = w + PAR;
    for (int i = 0; i < n; i++) begin
      if (i < w) b = (inst == 0) ? v[i] : v[w-1-i];
      else       b = pb_;
      if (rdy_last && i == n - 1) a_rdy = 1'b1;
      if (inst == 0) begin a_din = b; a_en = 1'b1; end
      else           begin b_din = b; b_en = 1'b1; end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    a_en = 1'b0;
    b_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [63:0] v;

  initial begin
    #3;
    chk("rst_cmd", 64'(a_cmd), 64'd0);
    chk("rst_data", 64'(a_data), 64'd0);
    chk("rst_valid", 64'(a_vld), 64'd0);
    chk("rst_overrun", 64'(a_ovr), 64'd0);
    chk("rst_abort", 64'(a_abt), 64'd0);
    chk("rst_perr", 64'(a_pe), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // LSB-first default frame
    a_rdy = 1'b1;
    v = 64'hA5123456;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    chk("lsb_valid", 64'(a_vld), 64'd1);
    chk("lsb_cmd", 64'(a_cmd), 64'hA5);
    idle(2);

    // abort after 10 bits, then a clean frame
    push(0, K_ABT, 16'd0, 64'd0, 1'b0);
    v = 64'h3FF;
    send_frame(0, v, 10 - PAR, 1'b1, 1'b0);
    a_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_pulse", 64'(a_abt), 64'd1);
    chk("abort_valid", 64'(a_vld), 64'd0);
    idle(1);
    chk("abort_clear", 64'(a_abt), 64'd0);
    v = 64'h01000002;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    idle(2);

    // overrun: two back-to-back frames, consumer stalled
    a_rdy = 1'b0;
    v = 64'h11000001;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    push(0, K_OVR, 16'd0, 64'd0, 1'b0);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    v = 64'h22000002;
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    chk("ovr_pulse", 64'(a_ovr), 64'd1);
    chk("ovr_cmd_kept", 64'(a_cmd), 64'h11);
    a_en = 1'b0;
    a_rdy = 1'b1;
    @(posedge clk); #1;
    a_rdy = 1'b0;
    chk("ovr_accept_clears", 64'(a_vld), 64'd0);
    chk("ovr_no_repeat", 64'(a_ovr), 64'd0);
    idle(2);

    // ready on the completion edge while holding a frame
    v = 64'h22000002;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    v = 64'h33000003;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b1);
    chk("simul_cmd", 64'(a_cmd), 64'h33);
    chk("simul_valid", 64'(a_vld), 64'd1);
    chk("simul_no_ovr", 64'(a_ovr), 64'd0);
    idle(2);

    // reset with a held frame and a partial frame in flight
    a_rdy = 1'b0;
    v = 64'h44000004;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    v = 64'h55555555;
    send_frame(0, v, 10 - PAR, 1'b1, 1'b0);
    #2;
    rst  = 1'b1;
    a_en = 1'b0;
    #1;
    chk("mid_rst_cmd", 64'(a_cmd), 64'd0);
    chk("mid_rst_data", 64'(a_data), 64'd0);
    chk("mid_rst_valid", 64'(a_vld), 64'd0);
    chk("mid_rst_perr", 64'(a_pe), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    chk("post_rst_abort", 64'(a_abt), 64'd0);
    chk("post_rst_ovr", 64'(a_ovr), 64'd0);
    a_rdy = 1'b1;
    v = 64'h55000005;
    exp_frame(0, v, 32, 8, ^v[31:0]);
    send_frame(0, v, 32, ^v[31:0], 1'b0);
    chk("post_rst_cmd", 64'(a_cmd), 64'h55);
    idle(2);

`ifdef SIPO_FRAME_PARITY_EN
    v = 64'h00000001;
    exp_frame(0, v, 32, 8, 1'b0);
    send_frame(0, v, 32, 1'b0, 1'b0);
    chk("par_bad", 64'(a_pe), 64'd1);
    exp_frame(0, v, 32, 8, 1'b1);
    send_frame(0, v, 32, 1'b1, 1'b0);
    chk("par_good", 64'(a_pe), 64'd0);
    idle(2);
`endif

    // MSB-first narrow build
    v = 64'h9C3;
    exp_frame(1, v, 12, 4, ^v[11:0]);
    send_frame(1, v, 12, ^v[11:0], 1'b0);
    chk("msb_cmd", 64'(b_cmd), 64'h9);
    chk("msb_data", 64'(b_data), 64'hC3);
    idle(5);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
